rr_mux_sel_arbiter: RTL and testbench

Four-channel round-robin arbiter that generates the 2-bit `sel` for the downstream 4:1 mux (channels a, b, c, d map to `sel` 0..3). It accepts one request line per mux input and grants exactly one channel at a time. A hold counter bounds the number of consecutive cycles one channel may keep the grant while others wait. The block carries its own immediate and concurrent assertions on grant legality, matching the checking style of the mux it feeds.

---
 rtl/rr_mux_sel_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_rr_mux_sel_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/rr_mux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// rr_mux_sel_arbiter
//
// Four-channel round-robin arbiter that produces the 2-bit select for a
// downstream 4:1 mux (channels a, b, c, d map to sel 0..3). One channel is
// granted at a time. A hold counter bounds how many consecutive cycles a
// channel may keep the grant while other channels are waiting; a sole
// requester keeps the grant indefinitely.
//
// Parameters
//   MAX_HOLD : maximum consecutive granted cycles per channel while another
//              channel requests. Legal range 1..15.
//
// Ports
//   clk   in  1 : clock, rising edge
//   rst   in  1 : asynchronous, active-high reset
//   req   in  4 : request per channel (bit i = mux input i)
//   gnt   out 4 : registered one-hot grant, zero when idle
//   sel   out 2 : registered binary encoding of gnt, held while idle
//   valid out 1 : registered, high while any grant is active
//
// Timing: one cycle from req to gnt/sel/valid, zero-bubble handover between
// channels, sel only moves when a new non-zero grant is issued.
// -----------------------------------------------------------------------------
module rr_mux_sel_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Last hold_cnt value before a waiting channel forces rotation.
    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD - 1);

    state_t     state;
    logic [1:0] last;
    logic [3:0] hold_cnt;

    // Rotating priority search: first requesting channel at start,
    // start+1, start+2, start+3 (mod 4). Only used when r is non-zero.
    function automatic logic [1:0] rr_search(input logic [3:0] r,
                                             input logic [1:0] start);
        logic [1:0] idx;
        logic       hit;
        rr_search = start;
        hit       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!hit && r[idx]) begin
                rr_search = idx;
                hit       = 1'b1;
            end
        end
    endfunction

    // -------------------------------------------------------------------------
    // Search candidates for the current cycle
    // -------------------------------------------------------------------------
    logic [1:0] win_idle;    // search from last+1, used when leaving IDLE
    logic [1:0] win_next;    // search from current channel+1, used on handover
    logic       others;      // some channel other than the granted one requests
    logic       own_req;     // granted channel still requests

    // NOTE: combinational logic uses blocking assignments and gives every
    // output a value on every path so no latch is inferred.
    always_comb begin
        win_idle = rr_search(req, last + 2'd1);
        win_next = rr_search(req, sel + 2'd1);
        others   = |(req & ~gnt);
        own_req  = req[sel];
    end

    // -------------------------------------------------------------------------
    // Arbitration FSM with registered outputs
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            sel      <= 2'd0;
            valid    <= 1'b0;
            last     <= 2'd3;     // first search after reset starts at channel 0
            hold_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= GRANT;
                        gnt      <= 4'b0001 << win_idle;
                        sel      <= win_idle;
                        valid    <= 1'b1;
                        last     <= win_idle;
                        hold_cnt <= 4'd0;
                    end
                end

                GRANT: begin
                    if (!own_req) begin
                        if (others) begin
                            // Owner released: hand over on the same edge.
                            gnt      <= 4'b0001 << win_next;
                            sel      <= win_next;
                            last     <= win_next;
                            hold_cnt <= 4'd0;
                        end else begin
                            // Nobody requests: drop to idle, sel keeps its value
                            // so the mux select never glitches.
                            state    <= IDLE;
                            gnt      <= 4'b0000;
                            valid    <= 1'b0;
                            hold_cnt <= 4'd0;
                        end
                    end else if (others && hold_cnt == HOLD_LIM) begin
                        // Hold budget used up while others wait: force rotation.
                        // The search from sel+1 reaches a waiting channel before
                        // wrapping back to the owner.
                        gnt      <= 4'b0001 << win_next;
                        sel      <= win_next;
                        last     <= win_next;
                        hold_cnt <= 4'd0;
                    end else if (hold_cnt != HOLD_LIM) begin
                        // Keep the grant; the counter saturates so a long sole
                        // requester rotates at once when a competitor appears.
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    gnt   <= 4'b0000;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Embedded grant-legality checks (inactive while rst is high)
    // -------------------------------------------------------------------------
    a_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt))
        else $error("%0t rr_mux_sel_arbiter: gnt %b is not one-hot or zero", $time, gnt);

    a_valid_any: assert property (@(posedge clk) disable iff (rst) valid == (|gnt))
        else $error("%0t rr_mux_sel_arbiter: valid %b disagrees with gnt %b", $time, valid, gnt);

    a_sel_match: assert property (@(posedge clk) disable iff (rst) valid |-> gnt[sel])
        else $error("%0t rr_mux_sel_arbiter: sel %0d does not match gnt %b", $time, sel, gnt);

    // Checker history: the grant and request seen on the previous edge.
    // gnt observed at edge t was decided from chk_req_q (req at edge t-1).
    logic [3:0] chk_gnt_q;
    logic [3:0] chk_req_q;
    logic [4:0] chk_run;    // edges on which the same channel was kept while others waited
    logic       chk_kept;

    always_comb begin
        chk_kept = (|gnt) && (gnt == chk_gnt_q) && (|(chk_req_q & ~chk_gnt_q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_gnt_q <= 4'b0000;
            chk_req_q <= 4'b0000;
            chk_run   <= 5'd0;
        end else begin
            chk_gnt_q <= gnt;
            chk_req_q <= req;
            chk_run   <= chk_kept ? chk_run + 5'd1 : 5'd0;

            // Any active grant must be backed by a request on the deciding edge.
            a_req_backed: assert ((gnt & ~chk_req_q) == 4'b0000)
                else $error("%0t rr_mux_sel_arbiter: gnt %b issued without req %b",
                            $time, gnt, chk_req_q);

            // MAX_HOLD granted cycles means at most MAX_HOLD-1 kept edges.
            if (chk_kept) begin
                a_max_hold: assert (chk_run < 5'(MAX_HOLD - 1))
                    else $error("%0t rr_mux_sel_arbiter: gnt %b held beyond %0d cycles while others waited",
                                $time, gnt, MAX_HOLD);
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_mux_sel_arbiter
//
// Directed bench for rr_mux_sel_arbiter (MAX_HOLD = 4). Inputs change 1 time
// unit after a rising edge and outputs are compared at that same point, so
// each comparison sees the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_rr_mux_sel_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;

    int n_eval;
    int n_fail;

    rr_mux_sel_arbiter #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .gnt   (gnt),
        .sel   (sel),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare all three outputs against a channel grant (ch < 0 means idle).
    task automatic expect_out(input string tag, input int ch, input logic [1:0] idle_sel);
        logic [3:0] g;
        if (ch < 0) begin
            check({tag, ".gnt"},   32'(gnt),   32'h0);
            check({tag, ".sel"},   32'(sel),   32'(idle_sel));
            check({tag, ".valid"}, 32'(valid), 32'h0);
        end else begin
            g = 4'b0001 << ch;
            check({tag, ".gnt"},   32'(gnt),   32'(g));
            check({tag, ".sel"},   32'(sel),   32'(ch));
            check({tag, ".valid"}, 32'(valid), 32'h1);
        end
    endtask

    // Apply req, take one rising edge, settle 1 unit.
    task automatic cyc(input logic [3:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_eval = 0;
        n_fail = 0;
        rst    = 1'b1;
        req    = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", -1, 2'd0);
        rst = 1'b0;

        // 1: idle after reset release
        for (int i = 0; i < 5; i++) begin
            cyc(4'b0000);
            expect_out($sformatf("idle%0d", i), -1, 2'd0);
        end

        // 2: sole requester on channel 2 keeps the grant
        for (int i = 0; i < 20; i++) begin
            cyc(4'b0100);
            expect_out($sformatf("sole%0d", i), 2, 2'd0);
        end
        cyc(4'b0000);
        expect_out("sole_drop", -1, 2'd2);      // sel holds last value

        // Reset pulse so the rotation sequence starts from channel 0
        rst = 1'b1;
        #1;
        expect_out("rst_pulse", -1, 2'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 3: all requesting, four cycles per channel
        for (int i = 0; i < 20; i++) begin
            cyc(4'b1111);
            expect_out($sformatf("rr%0d", i), (i / 4) % 4, 2'd0);
        end
        cyc(4'b1111);
        expect_out("rr20", 1, 2'd0);
        cyc(4'b1111);
        expect_out("rr21", 1, 2'd0);

        // 4: channel 1 releases, req=1001 -> search 2,3 picks 3; hold restarts
        cyc(4'b1001);
        expect_out("handover", 3, 2'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(4'b1001);
            expect_out($sformatf("hold3_%0d", i), 3, 2'd0);
        end
        cyc(4'b1001);
        expect_out("rotate_to0", 0, 2'd0);

        // 5: channel 3 alone, then drop to idle, then restart from last+1=0
        cyc(4'b1000);
        expect_out("to3", 3, 2'd0);
        cyc(4'b1000);
        expect_out("keep3", 3, 2'd0);
        cyc(4'b0000);
        expect_out("drop3", -1, 2'd3);
        cyc(4'b0000);
        expect_out("idle3", -1, 2'd3);
        cyc(4'b0011);
        expect_out("wrap0", 0, 2'd0);

        // 6: async reset during a channel-2 grant
        cyc(4'b0100);
        expect_out("to2", 2, 2'd0);
        #3;
        rst = 1'b1;
        #1;
        expect_out("async_rst", -1, 2'd0);
        req = 4'b1100;
        @(posedge clk);
        #1;
        expect_out("rst_held", -1, 2'd0);
        rst = 1'b0;
        cyc(4'b1100);
        expect_out("post_rst", 2, 2'd0);

        // Saturated hold counter: competitor arriving rotates on the next edge
        for (int i = 0; i < 5; i++) begin
            cyc(4'b0100);
            expect_out($sformatf("sat%0d", i), 2, 2'd0);
        end
        cyc(4'b1100);
        expect_out("sat_rotate", 3, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
